// File: rtl/fpnew_pkg.sv
// Shared FP unit definitions: formats, status flags, classification masks.
// Only the subset consumed by the non-computational writeback path is kept here.
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32,
        FP64,
        FP16,
        FP8,
        FP16ALT
    } fp_format_e;

    localparam int unsigned CLASS_MASK_BITS = 10;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    typedef enum logic [CLASS_MASK_BITS-1:0] {
        NEGINF     = 10'h001,
        NEGNORM    = 10'h002,
        NEGSUBNORM = 10'h004,
        NEGZERO    = 10'h008,
        POSZERO    = 10'h010,
        POSSUBNORM = 10'h020,
        POSNORM    = 10'h040,
        POSINF     = 10'h080,
        SNAN       = 10'h100,
        QNAN       = 10'h200
    } classmask_e;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP8:     return 8;
            FP16ALT: return 16;
            default: return 32;
        endcase
    endfunction

endpackage

// File: rtl/fpnew_noncomp_writeback_if.sv
// Handshake bundle between the non-computational FP unit, the writeback block
// and the register-file consumer. The slave modport is the writeback block.
interface fpnew_noncomp_writeback_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned RegWidth = 64,
    parameter type         TagType  = logic
);
    import fpnew_pkg::*;

    logic [WIDTH-1:0]    result_i;
    status_t             status_i;
    logic                extension_bit_i;
    classmask_e          class_mask_i;
    logic                is_class_i;
    TagType              tag_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic                flush_i;
    logic [RegWidth-1:0] wb_data_o;
    status_t             wb_status_o;
    TagType              wb_tag_o;
    logic                wb_valid_o;
    logic                wb_ready_i;
    status_t             fflags_o;
    logic                fflags_clear_i;
    logic                busy_o;

    modport master (
        output result_i, status_i, extension_bit_i, class_mask_i, is_class_i, tag_i,
        output in_valid_i, flush_i, wb_ready_i, fflags_clear_i,
        input  in_ready_o, wb_data_o, wb_status_o, wb_tag_o, wb_valid_o, fflags_o, busy_o
    );

    modport slave (
        input  result_i, status_i, extension_bit_i, class_mask_i, is_class_i, tag_i,
        input  in_valid_i, flush_i, wb_ready_i, fflags_clear_i,
        output in_ready_o, wb_data_o, wb_status_o, wb_tag_o, wb_valid_o, fflags_o, busy_o
    );

endinterface

// File: rtl/fpnew_wb_fifo.sv
// Generic in-order queue with synchronous flush; the head entry is read
// straight out of storage so it holds steady while the consumer stalls.
module fpnew_wb_fifo #(
    parameter int unsigned Depth   = 2,
    parameter type         entry_t = logic
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   flush_i,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef logic [PtrW-1:0] ptr_t;

    entry_t           mem [Depth];
    ptr_t             rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             push_en, pop_en;

    // Explicit wrap so non-power-of-two depths work.
    function automatic ptr_t wrap_inc(ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign push_en = push_i && !full_o && !flush_i;
    assign pop_en  = pop_i && !empty_o;

    // NOTE: storage is not reset; the empty flag masks stale contents on the head output.
    always_ff @(posedge clk_i) begin
        if (push_en) mem[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wrap_inc(wr_ptr_q);
            if (pop_en)  rd_ptr_q <= wrap_inc(rd_ptr_q);
            case ({push_en, pop_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o = empty_o ? entry_t'('0) : mem[rd_ptr_q];

endmodule

// File: rtl/fpnew_noncomp_writeback.sv
// Formats non-computational FP results into register-width writeback words,
// queues them in order and accumulates sticky fflags for retired entries.
module fpnew_noncomp_writeback
    import fpnew_pkg::*;
#(
    parameter fp_format_e  FpFormat = FP32,
    parameter int unsigned RegWidth = 64,
    parameter int unsigned Depth    = 2,
    parameter type         TagType  = logic
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    fpnew_noncomp_writeback_if.slave  bus
);

    localparam int unsigned WIDTH = fp_width(FpFormat);

    typedef struct packed {
        logic [RegWidth-1:0] data;
        status_t             status;
        TagType              tag;
    } entry_t;

    logic [RegWidth-1:0] fmt_data;
    entry_t              push_entry, head;
    logic                full, empty, push, pop;
    logic [4:0]          fflags_q;

    // NOTE: blocking assignments in always_comb; the later assignment overrides the default fill.
    always_comb begin
        fmt_data              = {RegWidth{bus.extension_bit_i}};
        fmt_data[WIDTH-1:0]   = bus.result_i;
        if (bus.is_class_i) begin
            fmt_data                      = '0;
            fmt_data[CLASS_MASK_BITS-1:0] = bus.class_mask_i;
        end
    end

    assign push_entry = '{data: fmt_data, status: bus.status_i, tag: bus.tag_i};

    // Ready depends only on registered fullness and flush, never on wb_ready_i.
    assign bus.in_ready_o = !full && !bus.flush_i;
    assign push           = bus.in_valid_i && bus.in_ready_o;
    assign pop            = !empty && bus.wb_ready_i;

    fpnew_wb_fifo #(
        .Depth   (Depth),
        .entry_t (entry_t)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (bus.flush_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // A clear coinciding with a retirement keeps the retiring flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fflags_q <= '0;
        else         fflags_q <= (bus.fflags_clear_i ? 5'b0 : fflags_q) | (pop ? head.status : 5'b0);
    end

    assign bus.wb_data_o   = head.data;
    assign bus.wb_status_o = head.status;
    assign bus.wb_tag_o    = head.tag;
    assign bus.wb_valid_o  = !empty;
    assign bus.busy_o      = !empty;
    assign bus.fflags_o    = fflags_q;

endmodule
